// File: rtl/fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fetch_unit: holds the PC and fetches 32-bit words for execute. While an     |
// | instruction executes, execute's load/store traffic goes through the single  |
// | memory port. Optional macro FETCH_HALT_ON_INVALID_EN halts the unit on a    |
// | decode fault reported by execute.                                           |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013,
  parameter int          DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic [31:0]           o_mem_addr,
  output logic                  o_mem_rd_ready,
  input  logic                  i_mem_rd_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic                  o_mem_wr_valid,
  input  logic                  i_mem_wr_ready,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic [2:0]            o_mem_wr_width,
  input  logic [31:0]           i_ex_addr,
  input  logic                  i_ex_rd_ready,
  output logic                  o_ex_rd_valid,
  output logic [DATA_WIDTH-1:0] o_ex_data,
  input  logic                  i_ex_wr_valid,
  output logic                  o_ex_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_ex_data,
  input  logic [2:0]            i_ex_wr_width,
  output logic [31:0]           o_inst,
  output logic [31:0]           o_pc,
  input  logic                  i_finished,
  input  logic                  i_pc_change,
  input  logic [31:0]           i_new_pc,
  input  logic                  i_invalid_inst,
  output logic                  o_halted,
  output logic [31:0]           o_fault_pc
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_inst, w_inst_next;
  logic [31:0] r_fault_pc, w_fault_pc_next;
  logic        w_invalid_halt;

`ifdef FETCH_HALT_ON_INVALID_EN
  assign w_invalid_halt = i_invalid_inst;
`else
  logic w_unused_invalid;
  assign w_unused_invalid = i_invalid_inst;
  assign w_invalid_halt   = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_inst     <= NOP_WORD;
      r_fault_pc <= 32'h0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_inst     <= w_inst_next;
      r_fault_pc <= w_fault_pc_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_inst_next     = r_inst;
    w_fault_pc_next = r_fault_pc;
    case (r_state)
      S_FETCH: begin
        if (i_mem_rd_valid) begin
          w_inst_next  = i_mem_data[31:0];
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_invalid_halt) begin
          w_state_next    = S_HALT;
          w_fault_pc_next = r_pc;
        end else if (i_finished) begin
          // Redirect targets must be word aligned; a misaligned one stops the unit.
          if (i_pc_change && (i_new_pc[1:0] != 2'b00)) begin
            w_state_next    = S_HALT;
            w_fault_pc_next = r_pc;
          end else begin
            w_state_next = S_FETCH;
            w_pc_next    = i_pc_change ? i_new_pc : (r_pc + 32'd4);
          end
        end
      end
      default: ;
    endcase
  end

  // Memory requests are held off while reset is asserted, whatever the state.
  always_comb begin
    o_mem_addr     = 32'h0;
    o_mem_rd_ready = 1'b0;
    o_mem_wr_valid = 1'b0;
    o_mem_data     = '0;
    o_mem_wr_width = 3'd0;
    o_ex_rd_valid  = 1'b0;
    o_ex_data      = '0;
    o_ex_wr_ready  = 1'b0;
    o_inst         = NOP_WORD;
    if (i_rst_n) begin
      case (r_state)
        S_FETCH: begin
          o_mem_addr     = r_pc;
          o_mem_rd_ready = 1'b1;
        end
        S_EXEC: begin
          o_inst         = r_inst;
          o_mem_addr     = i_ex_addr;
          o_mem_rd_ready = i_ex_rd_ready & ~w_invalid_halt;
          o_ex_rd_valid  = i_mem_rd_valid;
          o_ex_data      = i_mem_data;
          o_mem_wr_valid = i_ex_wr_valid & ~w_invalid_halt;
          o_ex_wr_ready  = i_mem_wr_ready;
          o_mem_data     = i_ex_data;
          o_mem_wr_width = i_ex_wr_width;
        end
        default: ;
      endcase
    end
  end

  assign o_pc       = r_pc;
  assign o_halted   = (r_state == S_HALT);
  assign o_fault_pc = r_fault_pc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_fetch_unit: directed scenarios plus randomized instruction streams       |
// | checked against a PC/halt model. Rev 1.0                                    |
// +-----------------------------------------------------------------------------+
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_fetch_unit;
  localparam int          DW     = `DATA_WIDTH;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef FETCH_HALT_ON_INVALID_EN
  localparam bit INV_HALT = 1'b1;
`else
  localparam bit INV_HALT = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [31:0]   o_mem_addr;
  logic          o_mem_rd_ready;
  logic          i_mem_rd_valid;
  logic [DW-1:0] i_mem_data;
  logic          o_mem_wr_valid;
  logic          i_mem_wr_ready;
  logic [DW-1:0] o_mem_data;
  logic [2:0]    o_mem_wr_width;
  logic [31:0]   i_ex_addr;
  logic          i_ex_rd_ready;
  logic          o_ex_rd_valid;
  logic [DW-1:0] o_ex_data;
  logic          i_ex_wr_valid;
  logic          o_ex_wr_ready;
  logic [DW-1:0] i_ex_data;
  logic [2:0]    i_ex_wr_width;
  logic [31:0]   o_inst;
  logic [31:0]   o_pc;
  logic          i_finished;
  logic          i_pc_change;
  logic [31:0]   i_new_pc;
  logic          i_invalid_inst;
  logic          o_halted;
  logic [31:0]   o_fault_pc;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit #(.RESET_PC(RST_PC), .NOP_WORD(NOP), .DATA_WIDTH(DW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_mem_addr(o_mem_addr), .o_mem_rd_ready(o_mem_rd_ready),
    .i_mem_rd_valid(i_mem_rd_valid), .i_mem_data(i_mem_data),
    .o_mem_wr_valid(o_mem_wr_valid), .i_mem_wr_ready(i_mem_wr_ready),
    .o_mem_data(o_mem_data), .o_mem_wr_width(o_mem_wr_width),
    .i_ex_addr(i_ex_addr), .i_ex_rd_ready(i_ex_rd_ready),
    .o_ex_rd_valid(o_ex_rd_valid), .o_ex_data(o_ex_data),
    .i_ex_wr_valid(i_ex_wr_valid), .o_ex_wr_ready(o_ex_wr_ready),
    .i_ex_data(i_ex_data), .i_ex_wr_width(i_ex_wr_width),
    .o_inst(o_inst), .o_pc(o_pc),
    .i_finished(i_finished), .i_pc_change(i_pc_change), .i_new_pc(i_new_pc),
    .i_invalid_inst(i_invalid_inst), .o_halted(o_halted), .o_fault_pc(o_fault_pc)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no summary, expected finish");
    $fatal(1, "timeout");
  end

  task automatic idle();
    i_mem_rd_valid = 1'b0; i_mem_data = '0; i_mem_wr_ready = 1'b0;
    i_ex_addr = 32'h0; i_ex_rd_ready = 1'b0; i_ex_wr_valid = 1'b0;
    i_ex_data = '0; i_ex_wr_width = 3'd0; i_finished = 1'b0;
    i_pc_change = 1'b0; i_new_pc = 32'h0; i_invalid_inst = 1'b0;
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  // Leaves the bench just after a negedge with the unit in its first fetch cycle.
  task automatic do_reset();
    tick(); idle(); i_rst_n = 1'b0;
    tick(); i_rst_n = 1'b1;
  endtask

  // Answers the current fetch immediately and moves into the execute cycle.
  task automatic answer(input logic [31:0] word);
    i_mem_rd_valid = 1'b1; i_mem_data = '0; i_mem_data[31:0] = word;
    tick(); idle();
  endtask

  task automatic test_reset();
    idle(); i_rst_n = 1'b0;
    i_mem_rd_valid = 1'b1; i_ex_rd_ready = 1'b1; i_ex_wr_valid = 1'b1;
    #1;
    n_cmp++; if ({o_mem_rd_ready, o_mem_wr_valid} !== 2'b00) begin n_bad++; $display("FAIL reset_req: got %b want 00", {o_mem_rd_ready, o_mem_wr_valid}); end
    tick();
    #1;
    n_cmp++; if ({o_halted, o_fault_pc} !== 33'h0) begin n_bad++; $display("FAIL reset_halt_fault: got %b/%h want 0/0", o_halted, o_fault_pc); end
    n_cmp++; if ({o_inst, o_pc} !== {NOP, RST_PC}) begin n_bad++; $display("FAIL reset_inst_pc: got %h/%h want %h/%h", o_inst, o_pc, NOP, RST_PC); end
    n_cmp++; if (o_mem_rd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_rd_ready: got %b want 0", o_mem_rd_ready); end
    tick(); idle(); i_rst_n = 1'b1;
    #1;
    n_cmp++; if ({o_mem_addr, o_mem_rd_ready} !== {RST_PC, 1'b1}) begin n_bad++; $display("FAIL reset_first_fetch: got %h/%b want %h/1", o_mem_addr, o_mem_rd_ready, RST_PC); end
  endtask

  task automatic test_basic_fetch();
    i_ex_wr_valid = 1'b1; i_mem_wr_ready = 1'b1; i_ex_rd_ready = 1'b1;
    i_mem_rd_valid = 1'b1; i_mem_data = '0; i_mem_data[31:0] = 32'h0050_0093;
    #1;
    n_cmp++; if ({o_ex_wr_ready, o_mem_wr_valid, o_ex_rd_valid} !== 3'b000) begin n_bad++; $display("FAIL fetch_ex_forced_low: got %b want 000", {o_ex_wr_ready, o_mem_wr_valid, o_ex_rd_valid}); end
    n_cmp++; if (o_inst !== NOP) begin n_bad++; $display("FAIL fetch_nop: got %h want %h", o_inst, NOP); end
    tick(); idle();
    #1;
    n_cmp++; if ({o_inst, o_pc} !== {32'h0050_0093, 32'h100}) begin n_bad++; $display("FAIL exec_inst_pc: got %h/%h want 00500093/00000100", o_inst, o_pc); end
    i_finished = 1'b1;
    tick(); idle();
    #1;
    n_cmp++; if ({o_mem_addr, o_pc, o_inst} !== {32'h104, 32'h104, NOP}) begin n_bad++; $display("FAIL seq_next_fetch: got %h/%h/%h want 104/104/%h", o_mem_addr, o_pc, o_inst, NOP); end
  endtask

  task automatic test_jal();
    answer(32'h0FC0_006F);
    i_finished = 1'b1; i_pc_change = 1'b1; i_new_pc = 32'h200;
    tick(); idle();
    #1;
    n_cmp++; if ({o_mem_addr, o_mem_rd_ready, o_inst} !== {32'h200, 1'b1, NOP}) begin n_bad++; $display("FAIL jal_redirect: got %h/%b/%h want 200/1/%h", o_mem_addr, o_mem_rd_ready, o_inst, NOP); end
  endtask

  task automatic test_load_store();
    answer(32'h0000_2083);
    i_ex_addr = 32'h40; i_ex_rd_ready = 1'b1; i_pc_change = 1'b1; i_new_pc = 32'h300;
    for (int s = 0; s < 3; s++) begin
      #1;
      n_cmp++; if ({o_mem_addr, o_mem_rd_ready, o_ex_rd_valid, o_pc} !== {32'h40, 2'b10, 32'h200}) begin n_bad++; $display("FAIL load_stall%0d: got %h/%b/%b/%h want 40/1/0/200", s, o_mem_addr, o_mem_rd_ready, o_ex_rd_valid, o_pc); end
      tick();
    end
    i_mem_rd_valid = 1'b1; i_mem_data = '0; i_mem_data[31:0] = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if ({o_ex_rd_valid, o_ex_data[31:0], o_mem_addr} !== {1'b1, 32'hDEAD_BEEF, 32'h40}) begin n_bad++; $display("FAIL load_data: got %b/%h/%h want 1/deadbeef/40", o_ex_rd_valid, o_ex_data[31:0], o_mem_addr); end
    tick(); idle();
    i_ex_addr = 32'h44; i_ex_wr_valid = 1'b1; i_ex_data = '0; i_ex_data[31:0] = 32'h1234_5678;
    i_ex_wr_width = 3'd4; i_mem_wr_ready = 1'b1; i_finished = 1'b1;
    #1;
    n_cmp++; if ({o_mem_wr_valid, o_ex_wr_ready, o_mem_data[31:0], o_mem_wr_width, o_mem_addr} !== {2'b11, 32'h1234_5678, 3'd4, 32'h44}) begin n_bad++; $display("FAIL store_pass: got %b%b/%h/%0d/%h want 11/12345678/4/44", o_mem_wr_valid, o_ex_wr_ready, o_mem_data[31:0], o_mem_wr_width, o_mem_addr); end
    tick(); idle();
    #1;
    n_cmp++; if ({o_mem_addr, o_pc} !== {32'h204, 32'h204}) begin n_bad++; $display("FAIL redirect_ignored: got %h/%h want 204/204", o_mem_addr, o_pc); end
  endtask

  task automatic test_wrap();
    answer(32'h0000_0013);
    i_finished = 1'b1; i_pc_change = 1'b1; i_new_pc = 32'hFFFF_FFFC;
    tick(); idle();
    #1;
    n_cmp++; if (o_mem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_top: got %h want fffffffc", o_mem_addr); end
    answer(32'h0000_0013);
    i_finished = 1'b1;
    tick(); idle();
    #1;
    n_cmp++; if ({o_mem_addr, o_pc, o_halted} !== 65'h0) begin n_bad++; $display("FAIL wrap_zero: got %h/%h/%b want 0/0/0", o_mem_addr, o_pc, o_halted); end
  endtask

  task automatic test_invalid();
    answer(32'h0000_0013);
    i_finished = 1'b1; i_pc_change = 1'b1; i_new_pc = 32'h10;
    tick(); idle();
    answer(32'hFFFF_FFFF);
    i_invalid_inst = 1'b1; i_ex_rd_ready = 1'b1; i_ex_addr = 32'h80; i_finished = 1'b1;
    #1;
    n_cmp++; if (o_mem_rd_ready !== !INV_HALT) begin n_bad++; $display("FAIL invalid_req: got %b want %b", o_mem_rd_ready, !INV_HALT); end
    tick(); idle();
    #1;
    n_cmp++; if (o_halted !== INV_HALT) begin n_bad++; $display("FAIL invalid_halt: got %b want %b", o_halted, INV_HALT); end
    n_cmp++; if ({o_fault_pc, o_mem_addr} !== (INV_HALT ? {32'h10, 32'h0} : {32'h0, 32'h14})) begin n_bad++; $display("FAIL invalid_pc: got fault %h addr %h, halt mode %b", o_fault_pc, o_mem_addr, INV_HALT); end
    do_reset();
  endtask

  task automatic test_misaligned();
    answer(32'h0000_0013);
    i_finished = 1'b1; i_pc_change = 1'b1; i_new_pc = 32'h202;
    tick(); idle();
    #1;
    n_cmp++; if ({o_halted, o_fault_pc, o_inst} !== {1'b1, 32'h100, NOP}) begin n_bad++; $display("FAIL misaligned_halt: got %b/%h/%h want 1/100/%h", o_halted, o_fault_pc, o_inst, NOP); end
    for (int c = 0; c < 10; c++) begin
      i_ex_rd_ready = 1'b1; i_ex_wr_valid = 1'b1; i_mem_rd_valid = 1'b1; i_finished = 1'b1;
      #1;
      n_cmp++; if ({o_mem_rd_ready, o_mem_wr_valid, o_halted} !== 3'b001) begin n_bad++; $display("FAIL halt_quiet%0d: got %b want 001", c, {o_mem_rd_ready, o_mem_wr_valid, o_halted}); end
      tick();
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    tick(); tick();
    i_rst_n = 1'b0; i_mem_rd_valid = 1'b1; i_mem_data = '0; i_mem_data[31:0] = 32'hBAD0_BAD0;
    #1;
    n_cmp++; if ({o_mem_rd_ready, o_mem_wr_valid} !== 2'b00) begin n_bad++; $display("FAIL midreset_req: got %b want 00", {o_mem_rd_ready, o_mem_wr_valid}); end
    tick(); i_rst_n = 1'b1; idle();
    #1;
    n_cmp++; if ({o_mem_addr, o_mem_rd_ready, o_inst} !== {RST_PC, 1'b1, NOP}) begin n_bad++; $display("FAIL midreset_refetch: got %h/%b/%h want %h/1/%h", o_mem_addr, o_mem_rd_ready, o_inst, RST_PC, NOP); end
    tick();
    #1;
    n_cmp++; if (o_inst !== NOP) begin n_bad++; $display("FAIL stale_discarded: got %h want %h", o_inst, NOP); end
    answer(32'h0010_0113);
    #1;
    n_cmp++; if (o_inst !== 32'h0010_0113) begin n_bad++; $display("FAIL refetch_word: got %h want 00100113", o_inst); end
  endtask

  task automatic test_random();
    logic [31:0] ref_pc, ref_fault, word, r32, npc;
    logic        halted, done, fin, chg, inv;
    int          stall, ncyc;
    do_reset();
    ref_pc = RST_PC; ref_fault = 32'h0; halted = 1'b0;
    for (int k = 0; k < 150; k++) begin
      stall = $urandom_range(0, 3);
      word  = $urandom;
      for (int s = 0; s <= stall; s++) begin
        i_mem_rd_valid = (s == stall); i_mem_data = '0; i_mem_data[31:0] = (s == stall) ? word : $urandom;
        i_ex_rd_ready = 1'($urandom); i_ex_wr_valid = 1'($urandom); i_mem_wr_ready = 1'($urandom);
        #1;
        n_cmp++; if ({o_mem_addr, o_mem_rd_ready, o_halted, o_fault_pc} !== {ref_pc, 2'b10, 32'h0}) begin n_bad++; $display("FAIL rnd_fetch k%0d: got %h/%b/%b/%h want %h/1/0/0", k, o_mem_addr, o_mem_rd_ready, o_halted, o_fault_pc, ref_pc); end
        n_cmp++; if ({o_inst, o_ex_rd_valid, o_ex_wr_ready, o_mem_wr_valid} !== {NOP, 3'b000}) begin n_bad++; $display("FAIL rnd_fetch_quiet k%0d: got %h/%b want %h/000", k, o_inst, {o_ex_rd_valid, o_ex_wr_ready, o_mem_wr_valid}, NOP); end
        tick();
      end
      idle();
      ncyc = $urandom_range(1, 4);
      done = 1'b0;
      for (int c = 0; !done; c++) begin
        fin = (c == ncyc - 1);
        inv = ($urandom_range(0, 15) == 0);
        chg = ($urandom_range(0, 2) == 0);
        r32 = $urandom;
        case ($urandom_range(0, 15))
          0:       npc = {r32[31:2], 2'b01 + 2'($urandom_range(0, 2))};
          1:       npc = 32'hFFFF_FFFC;
          default: npc = {r32[31:2], 2'b00};
        endcase
        i_finished = fin; i_invalid_inst = inv; i_pc_change = chg; i_new_pc = npc;
        i_ex_addr = $urandom; i_ex_rd_ready = 1'($urandom); i_ex_wr_valid = 1'($urandom);
        i_mem_rd_valid = 1'($urandom); i_mem_wr_ready = 1'($urandom); i_ex_wr_width = 3'($urandom);
        i_mem_data = '0; i_mem_data[31:0] = $urandom; i_ex_data = '0; i_ex_data[31:0] = $urandom;
        #1;
        n_cmp++; if ({o_inst, o_pc} !== {word, ref_pc}) begin n_bad++; $display("FAIL rnd_exec_inst k%0d: got %h/%h want %h/%h", k, o_inst, o_pc, word, ref_pc); end
        n_cmp++; if ({o_mem_addr, o_mem_rd_ready, o_mem_wr_valid} !== {i_ex_addr, i_ex_rd_ready & !(INV_HALT & inv), i_ex_wr_valid & !(INV_HALT & inv)}) begin n_bad++; $display("FAIL rnd_exec_req k%0d: got %h/%b%b want %h/%b%b", k, o_mem_addr, o_mem_rd_ready, o_mem_wr_valid, i_ex_addr, i_ex_rd_ready & !(INV_HALT & inv), i_ex_wr_valid & !(INV_HALT & inv)); end
        n_cmp++; if ({o_ex_rd_valid, o_ex_data, o_ex_wr_ready, o_mem_data, o_mem_wr_width} !== {i_mem_rd_valid, i_mem_data, i_mem_wr_ready, i_ex_data, i_ex_wr_width}) begin n_bad++; $display("FAIL rnd_exec_pass k%0d: got %b/%h/%b/%h/%0d want %b/%h/%b/%h/%0d", k, o_ex_rd_valid, o_ex_data, o_ex_wr_ready, o_mem_data, o_mem_wr_width, i_mem_rd_valid, i_mem_data, i_mem_wr_ready, i_ex_data, i_ex_wr_width); end
        if (INV_HALT && inv) begin
          halted = 1'b1; ref_fault = ref_pc;
        end else if (fin) begin
          if (chg && (npc % 4 != 0)) begin
            halted = 1'b1; ref_fault = ref_pc;
          end else begin
            ref_pc = chg ? npc : ref_pc + 32'd4;
          end
        end
        done = halted || fin;
        tick(); idle();
      end
      if (halted) begin
        i_ex_rd_ready = 1'b1; i_ex_wr_valid = 1'b1;
        #1;
        n_cmp++; if ({o_halted, o_fault_pc, o_inst, o_mem_rd_ready, o_mem_wr_valid} !== {1'b1, ref_fault, NOP, 2'b00}) begin n_bad++; $display("FAIL rnd_halt k%0d: got %b/%h/%h/%b%b want 1/%h/%h/00", k, o_halted, o_fault_pc, o_inst, o_mem_rd_ready, o_mem_wr_valid, ref_fault, NOP); end
        do_reset();
        ref_pc = RST_PC; ref_fault = 32'h0; halted = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_jal();
    test_load_store();
    test_wrap();
    test_invalid();
    test_misaligned();
    test_reset_mid_fetch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
